seed_pool: RTL



---
 rtl/seed_pool_pkg.sv | 30 +++
 rtl/seed_health_test.sv | 74 +++++++
 rtl/seed_pool.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seed_pool_pkg.sv
// Shared constants for the Zkr seed path: OPST encodings, seed CSR field
// positions and the pool state type, so the CSR stage decodes the same values.
package seed_pool_pkg;

    localparam logic [1:0] OPST_BIST = 2'b00;
    localparam logic [1:0] OPST_WAIT = 2'b01;
    localparam logic [1:0] OPST_ES16 = 2'b10;
    localparam logic [1:0] OPST_DEAD = 2'b11;

    localparam int unsigned SEED_OPST_LSB    = 30;
    localparam int unsigned SEED_OPST_W      = 2;
    localparam int unsigned SEED_ENTROPY_LSB = 0;
    localparam int unsigned SEED_ENTROPY_W   = 16;

    typedef enum logic [1:0] {
        ST_BIST = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } pool_state_t;

    function automatic logic [31:0] seed_format(input logic [SEED_OPST_W-1:0]    opst,
                                                input logic [SEED_ENTROPY_W-1:0] entropy);
        logic [31:0] v;
        v = '0;
        v[SEED_OPST_LSB +: SEED_OPST_W]       = opst;
        v[SEED_ENTROPY_LSB +: SEED_ENTROPY_W] = entropy;
        return v;
    endfunction

endpackage

// File: rtl/seed_health_test.sv
// Continuous health tests on the raw noise stream: repetition count and
// adaptive proportion. Fail is combinational on the bit being sampled.
module seed_health_test #(
    parameter int unsigned RCT_CUTOFF = 32,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 56
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_bit,
    input  logic bit_valid,
    input  logic clear,
    output logic Fail
);

    localparam int unsigned RW = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned WW = $clog2(APT_WINDOW + 1);

    logic          prev_bit;
    logic [RW-1:0] run_cnt;
    logic [RW-1:0] run_next;
    logic          ref_bit;
    logic [WW-1:0] win_cnt;
    logic [WW-1:0] match_cnt;
    logic [WW-1:0] match_next;
    logic          rct_fail;
    logic          apt_fail;

    always_comb begin
        // run_cnt == 0 means no previous bit since reset/clear
        if (run_cnt == '0 || raw_bit != prev_bit)
            run_next = RW'(1);
        else
            run_next = run_cnt + RW'(1);

        if (win_cnt == '0)
            match_next = WW'(1);
        else if (raw_bit == ref_bit)
            match_next = match_cnt + WW'(1);
        else
            match_next = match_cnt;

        rct_fail = bit_valid && (run_next == RW'(RCT_CUTOFF));
        apt_fail = bit_valid && (match_next == WW'(APT_CUTOFF));
        Fail     = rct_fail || apt_fail;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_bit  <= 1'b0;
            run_cnt   <= '0;
            ref_bit   <= 1'b0;
            win_cnt   <= '0;
            match_cnt <= '0;
        end else if (clear || Fail) begin
            prev_bit  <= 1'b0;
            run_cnt   <= '0;
            ref_bit   <= 1'b0;
            win_cnt   <= '0;
            match_cnt <= '0;
        end else if (bit_valid) begin
            prev_bit  <= raw_bit;
            run_cnt   <= run_next;
            match_cnt <= match_next;
            if (win_cnt == '0)
                ref_bit <= raw_bit;
            if (win_cnt == WW'(APT_WINDOW - 1))
                win_cnt <= '0;
            else
                win_cnt <= win_cnt + WW'(1);
        end
    end

endmodule

// File: rtl/seed_pool.sv
// Entropy pool feeding the seed CSR: BIST/RUN/DEAD control, 16-bit packing,
// a small FIFO of entropy words and the formatted SeedValM value.
module seed_pool
    import seed_pool_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned BIST_BITS  = 64,
    parameter int unsigned RCT_CUTOFF = 32,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 56
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RawBitValid,
    input  logic        RawBit,
    input  logic        SeedReadM,
    output logic [31:0] SeedValM,
    output logic        Dead
);

    localparam int unsigned BW = $clog2(BIST_BITS + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    pool_state_t   state;
    logic [BW-1:0] bist_cnt;
    logic [15:0]   shreg;
    logic [3:0]    bit_cnt;
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic        bit_take;
    logic        fail;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic [15:0] word_next;
    logic [1:0]  opst;
    logic [15:0] entropy;

    assign bit_take = RawBitValid && (state != ST_DEAD);

    seed_health_test #(
        .RCT_CUTOFF(RCT_CUTOFF),
        .APT_WINDOW(APT_WINDOW),
        .APT_CUTOFF(APT_CUTOFF)
    ) u_health (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_bit  (RawBit),
        .bit_valid(bit_take),
        .clear    (state == ST_DEAD),
        .Fail     (fail)
    );

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(DEPTH));
        word_next  = {shreg[14:0], RawBit};
        pop        = SeedReadM && (state == ST_RUN) && !fifo_empty;
        // a full FIFO still accepts the word when the same cycle pops
        push       = bit_take && !fail && (state == ST_RUN) &&
                     (bit_cnt == 4'd15) && (!fifo_full || pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_BIST;
            bist_cnt <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (state == ST_DEAD) begin
            state <= ST_DEAD;
        end else if (fail) begin
            state    <= ST_DEAD;
            bist_cnt <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (state == ST_BIST && bit_take) begin
                if (bist_cnt == BW'(BIST_BITS - 1)) begin
                    state    <= ST_RUN;
                    bist_cnt <= '0;
                end else begin
                    bist_cnt <= bist_cnt + BW'(1);
                end
            end
            if (state == ST_RUN && bit_take) begin
                shreg   <= word_next;
                bit_cnt <= bit_cnt + 4'd1;
            end
            // pop clears its slot first; a same-cycle push into that slot wins
            if (pop) begin
                mem[rd_ptr] <= '0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr] <= word_next;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        case (state)
            ST_BIST: opst = OPST_BIST;
            ST_RUN:  opst = fifo_empty ? OPST_WAIT : OPST_ES16;
            default: opst = OPST_DEAD;
        endcase
        entropy = (opst == OPST_ES16) ? mem[rd_ptr] : 16'h0000;
    end

    assign SeedValM = seed_format(opst, entropy);
    assign Dead     = (state == ST_DEAD);

endmodule
